// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request sequencer: selector codes, default widths,
// sequencer FSM encoding and response flag bit positions.
package alu_pkg;

  localparam int unsigned ALU_DATA_W  = 8;
  localparam int unsigned ALU_OP_W    = 4;
  localparam int unsigned ALU_NUM_OPS = 6;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NOT = 4'd5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } seq_state_e;

  // rsp_flags = {err, sign, zero, oflow, cout}
  localparam int unsigned FLAGS_W    = 5;
  localparam int unsigned FLAG_COUT  = 0;
  localparam int unsigned FLAG_OFLOW = 1;
  localparam int unsigned FLAG_ZERO  = 2;
  localparam int unsigned FLAG_SIGN  = 3;
  localparam int unsigned FLAG_ERR   = 4;

endpackage

// File: rtl/alu_arb2.sv
// Two-way grant for the shared ALU. With ALU_SEQ_RR_EN defined, contention is resolved by a
// round-robin pointer that moves to the losing requester on every accept; otherwise req0
// always wins. A lone requester is always granted.
module alu_arb2 (
`ifdef ALU_SEQ_RR_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       accept,
`endif
  input  logic [1:0] valid,
  output logic [1:0] grant
);

`ifdef ALU_SEQ_RR_EN
  logic rr_q;

  // Grant the pointed-to requester when both are valid.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = rr_q ? 2'b10 : 2'b01;
  end

  // Pointer moves to the non-granted requester on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else if (accept) begin
      rr_q <= grant[0];
    end
  end
`else
  // Fixed priority: req0 wins any contention.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = 2'b01;
  end
`endif

endmodule

// File: rtl/alu_req_sequencer.sv
// Shares one ALU between the execution unit (req0) and the EA unit (req1). Each operation runs
// IDLE -> EXEC -> RESP: operands are latched onto the ALU inputs, the ALU result is captured
// after one execute cycle, and the result is held on the response channel until taken.
// Optional feature macro: ALU_SEQ_RR_EN (round-robin arbitration instead of req0 priority).
module alu_req_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = ALU_DATA_W,
  parameter int unsigned OP_W    = ALU_OP_W,
  parameter int unsigned NUM_OPS = ALU_NUM_OPS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [OP_W-1:0]    req0_op,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [OP_W-1:0]    req1_op,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [OP_W-1:0]    alu_sel,
  input  logic [DATA_W-1:0]  alu_x,
  input  logic               alu_cout,
  input  logic               alu_oflow,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [DATA_W-1:0]  rsp_x,
  output logic [FLAGS_W-1:0] rsp_flags
);

  seq_state_e         state_q;
  logic               id_q;
  logic               illegal_q;
  logic [1:0]         grant;
  logic               accept;
  logic [OP_W-1:0]    sel_op;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic               sel_illegal;
  logic [DATA_W-1:0]  exec_x;
  logic [FLAGS_W-1:0] exec_flags;

  alu_arb2 u_arb (
`ifdef ALU_SEQ_RR_EN
    .clk    (clk),
    .rst_n  (rst_n),
    .accept (accept),
`endif
    .valid  ({req1_valid, req0_valid}),
    .grant  (grant)
  );

  // Grant only counts while idle; readies are held low during reset as well.
  assign accept     = (state_q == StIdle) && (grant != 2'b00);
  assign req0_ready = rst_n && (state_q == StIdle) && grant[0];
  assign req1_ready = rst_n && (state_q == StIdle) && grant[1];

  // Payload of the granted requester.
  always_comb begin
    sel_op      = grant[1] ? req1_op : req0_op;
    sel_a       = grant[1] ? req1_a  : req0_a;
    sel_b       = grant[1] ? req1_b  : req0_b;
    sel_illegal = (32'(sel_op) >= NUM_OPS);
  end

  // Result and flags to capture at the end of EXEC; illegal ops ignore the ALU entirely.
  always_comb begin
    exec_x     = alu_x;
    exec_flags = '0;
    if (illegal_q) begin
      exec_x                = '0;
      exec_flags[FLAG_ZERO] = 1'b1;
      exec_flags[FLAG_ERR]  = 1'b1;
    end else begin
      exec_flags[FLAG_COUT]  = alu_cout;
      exec_flags[FLAG_OFLOW] = alu_oflow;
      exec_flags[FLAG_ZERO]  = (alu_x == '0);
      exec_flags[FLAG_SIGN]  = alu_x[DATA_W-1];
    end
  end

  // Sequencer FSM with registered ALU drive and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      id_q      <= 1'b0;
      illegal_q <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_x     <= '0;
      rsp_flags <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            alu_a     <= sel_a;
            alu_b     <= sel_b;
            alu_sel   <= sel_op;
            id_q      <= grant[1];
            illegal_q <= sel_illegal;
            state_q   <= StExec;
          end
        end
        StExec: begin
          rsp_x     <= exec_x;
          rsp_flags <= exec_flags;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state_q   <= StResp;
        end
        StResp: begin
          // No accept in the handshake cycle: the next grant is evaluated from IDLE.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
